// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a single-port async-read/sync-write data RAM; fixed M0 priority with a burst cap.
// Latency: 3 cycles per transaction (IDLE, ACCESS, DONE); requesters hold req until their 1-cycle ack.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_we,
    output logic [3:0]            ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  sel_err
);

    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int LANE = DATA_WIDTH / 4;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  sel_err_q, sel_err_d;

    logic                  sel_legal;
    logic                  m1_wins;
    logic [DATA_WIDTH-1:0] d_steer;

    always_comb begin
        sel_legal = 1'b0;
        case (sel_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
            default:                   sel_legal = 1'b0;
        endcase
    end

    // Masters supply low-aligned byte/half data; replicate it so it lands on whichever lane sel picks.
    always_comb begin
        d_steer = wdata_q;
        case (sel_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: d_steer = {4{wdata_q[LANE-1:0]}};
            4'b0011, 4'b1100:                   d_steer = {2{wdata_q[2*LANE-1:0]}};
            default:                            d_steer = wdata_q;
        endcase
    end

    assign m1_wins = m1_req && (!m0_req || (burst_q == BURST_MAX));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        burst_d    = burst_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        sel_err_d  = sel_err_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_ACCESS;
                    owner_d = m1_wins;
                    if (m1_wins) begin
                        we_d    = m1_we;
                        sel_d   = m1_sel;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        burst_d = '0;
                    end else begin
                        we_d    = m0_we;
                        sel_d   = m0_sel;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        if (!m1_req)
                            burst_d = '0;
                        else if (burst_q != BURST_MAX)
                            burst_d = burst_q + BW'(1);
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (owner_q)
                    m1_rdata_d = ram_q;
                else
                    m0_rdata_d = ram_q;
                if (we_q && !sel_legal)
                    sel_err_d = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            burst_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            burst_q    <= burst_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign ram_we   = (state_q == S_ACCESS) && we_q && sel_legal;
    assign ram_sel  = sel_q;
    assign ram_addr = addr_q;
    assign ram_d    = d_steer;
    assign m0_ack   = (state_q == S_DONE) && !owner_q;
    assign m1_ack   = (state_q == S_DONE) && owner_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural async-read/sync-write RAM.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_ack;
    logic [3:0]  m0_sel;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [3:0]  m1_sel;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [9:0]  ram_addr;
    logic [31:0] ram_d, ram_q;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];

    ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_d(ram_d),
        .ram_q(ram_q), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr][b*8 +: 8] <= ram_d[b*8 +: 8];
        end
    end
    assign ram_q = mem[ram_addr];

    // One transaction on master m; lat counts the request cycle as 1, so ack in cycle 3 gives lat=3.
    task automatic xact(input bit m, input logic we, input logic [3:0] sel, input logic [9:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output bit we_seen);
        @(posedge clk); #1;
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wd;
        end
        lat = 1; rd = '0; we_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ram_we) we_seen = 1'b1;
            if (m ? m1_ack : m0_ack) begin
                rd = m ? m1_rdata : m0_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({m0_ack, m1_ack, ram_we, sel_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {m0_ack, m1_ack, ram_we, sel_err});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
        end
        n_checks++;
        if ({ram_sel, ram_addr, ram_d} !== 46'h0) begin
            n_fail++; $display("FAIL reset_ram_bus: got sel=%h addr=%h d=%h expected 0", ram_sel, ram_addr, ram_d);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_rw;
        int lat; logic [31:0] rd; bit ws;
        xact(0, 1'b1, 4'b1111, 10'd5, 32'hDEADBEEF, lat, rd, ws);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", lat); end
        n_checks++;
        if (ws !== 1'b1) begin n_fail++; $display("FAIL write_we_seen: got %b expected 1", ws); end
        xact(0, 1'b0, 4'b1111, 10'd5, 32'h0, lat, rd, ws);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h expected DEADBEEF", rd); end
        n_checks++;
        if (ws !== 1'b0) begin n_fail++; $display("FAIL read_we_seen: got %b expected 0", ws); end
        @(posedge clk); #1;
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b expected 0", m0_ack); end
        n_checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %h expected DEADBEEF", m0_rdata); end
    endtask

    task automatic test_byte_lanes;
        int lat; logic [31:0] rd; bit ws;
        xact(0, 1'b1, 4'b1111, 10'd6, 32'h11223344, lat, rd, ws);
        xact(0, 1'b1, 4'b0010, 10'd6, 32'h000000AB, lat, rd, ws);
        xact(0, 1'b0, 4'b0000, 10'd6, 32'h0, lat, rd, ws);
        n_checks++;
        if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL byte_write: got %h expected 1122AB44", rd); end
        xact(0, 1'b1, 4'b1111, 10'd8, 32'h11223344, lat, rd, ws);
        xact(0, 1'b1, 4'b1100, 10'd8, 32'h0000BEEF, lat, rd, ws);
        xact(0, 1'b0, 4'b1111, 10'd8, 32'h0, lat, rd, ws);
        n_checks++;
        if (rd !== 32'hBEEF3344) begin n_fail++; $display("FAIL half_write: got %h expected BEEF3344", rd); end
    endtask

    task automatic test_m1_read;
        int lat; logic [31:0] rd; bit ws;
        xact(1, 1'b0, 4'b0000, 10'd5, 32'h0, lat, rd, ws);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL m1_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m1_read: got %h expected DEADBEEF", rd); end
        n_checks++;
        if (m0_rdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL m0_rdata_untouched: got %h expected BEEF3344", m0_rdata); end
    endtask

    task automatic test_sel_err;
        int lat; logic [31:0] rd; bit ws;
        xact(1, 1'b1, 4'b0101, 10'd6, 32'hFFFFFFFF, lat, rd, ws);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL bad_sel_ack: got latency %0d expected 3", lat); end
        n_checks++;
        if (ws !== 1'b0) begin n_fail++; $display("FAIL bad_sel_we: got %b expected 0", ws); end
        n_checks++;
        if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_set: got %b expected 1", sel_err); end
        xact(0, 1'b1, 4'b0000, 10'd6, 32'h00000000, lat, rd, ws);
        n_checks++;
        if (ws !== 1'b0) begin n_fail++; $display("FAIL zero_sel_we: got %b expected 0", ws); end
        xact(0, 1'b0, 4'b1111, 10'd6, 32'h0, lat, rd, ws);
        n_checks++;
        if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL bad_sel_data: got %h expected 1122AB44", rd); end
        n_checks++;
        if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_sticky: got %b expected 1", sel_err); end
    endtask

    task automatic test_simultaneous;
        int t0, t1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++;
        if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_clear: got %b expected 0", sel_err); end
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd6;
        t0 = 0; t1 = 0;
        for (int c = 2; c < 20; c++) begin
            @(posedge clk); #1;
            if (m0_ack) begin t0 = c; m0_req = 1'b0; end
            if (m1_ack) begin t1 = c; m1_req = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_checks++;
        if (t0 !== 3) begin n_fail++; $display("FAIL simul_m0_cycle: got %0d expected 3", t0); end
        n_checks++;
        if (t1 !== 6) begin n_fail++; $display("FAIL simul_m1_cycle: got %0d expected 6", t1); end
        n_checks++;
        if (m1_rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL simul_m1_data: got %h expected 1122AB44", m1_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] got;
        logic [9:0] exp_order;
        int n;
        exp_order = 10'b10_0001_0000;
        got = '0; n = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd5;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) begin
                got[n] = m1_ack;
                n++;
                if (n == 10) break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_checks++;
        if (n !== 10) begin n_fail++; $display("FAIL burst_count: got %0d grants expected 10", n); end
        n_checks++;
        if (got !== exp_order) begin n_fail++; $display("FAIL burst_order: got %b expected %b (bit0 first, 1=M1)", got, exp_order); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; bit ws;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_sel = 4'b1111; m0_addr = 10'd5;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({m0_ack, m1_ack, ram_we, sel_err} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {m0_ack, m1_ack, ram_we, sel_err});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata, ram_sel, ram_addr, ram_d} !== 110'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got rdata=%h ram_addr=%h ram_sel=%h expected 0", m0_rdata, ram_addr, ram_sel);
        end
        m0_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_no_ack: got %b expected 0", m0_ack); end
        m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'b1111; m0_addr = 10'd9; m0_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        m0_req = 1'b0; m0_we = 1'b0; rst = 1'b1;
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_write_no_ack: got %b expected 0", m0_ack); end
        xact(0, 1'b0, 4'b1111, 10'd9, 32'h0, lat, rd, ws);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst_write_commit: got %h expected CAFEF00D", rd); end
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_m1_read();
        test_sel_err();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
